// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: PC, imem req/ack, IF/ID register, redirect/stall/flush.
// Optional `IF_MISALIGN_EN traps misaligned redirect targets into ERR.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
  parameter int          MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        exMemPc,
  input  logic [31:0] exMemIn,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ifIdInstruction,
  output logic [31:0] ifIdIn,
  output logic        if_valid,
  output logic        fetch_err,
  output logic        misalign
);

  localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int TL = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    ERR
  } state_t;

  state_t        r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_ins;
  logic [31:0]   r_npc;
  logic          r_vld;
  logic          r_err;
  logic [31:0]   r_hold_ins;
  logic [31:0]   r_hold_npc;
  logic          r_hold_vld;
  logic [TW-1:0] r_tcnt;

  logic [31:0]   w_tgt;
  logic          w_bad;
  logic          w_ack;
  logic          w_tmo;
  logic [31:0]   w_npc;

  assign w_npc = r_pc + 32'd4;
  assign w_ack = (r_state == FETCH) && imem_ack;
  assign w_tmo = (MEM_TIMEOUT != 0) && (r_tcnt == TW'(TL));

`ifdef IF_MISALIGN_EN
  logic r_mis;

  assign w_tgt    = exMemIn;
  assign w_bad    = |exMemIn[1:0];
  assign misalign = r_mis;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mis <= 1'b0;
    end else if (r_state != ERR && exMemPc && w_bad) begin
      r_mis <= 1'b1;
    end
  end
`else
  logic w_unused_lsb;

  assign w_unused_lsb = |exMemIn[1:0];
  assign w_tgt        = {exMemIn[31:2], 2'b00};
  assign w_bad        = 1'b0;
  assign misalign     = 1'b0;
`endif

  assign imem_req        = (r_state == FETCH);
  assign imem_addr       = r_pc;
  assign pc              = r_pc;
  assign ifIdInstruction = r_ins;
  assign ifIdIn          = r_npc;
  assign if_valid        = r_vld;
  assign fetch_err       = r_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_ins      <= NOP_INSTR;
      r_npc      <= '0;
      r_vld      <= 1'b0;
      r_err      <= 1'b0;
      r_hold_ins <= '0;
      r_hold_npc <= '0;
      r_hold_vld <= 1'b0;
      r_tcnt     <= '0;
    end else if (r_state == ERR) begin
      r_ins  <= NOP_INSTR;
      r_vld  <= 1'b0;
      r_tcnt <= '0;
    end else if (exMemPc) begin
      // Redirect beats ack, stall and timeout alike.
      r_pc       <= w_tgt;
      r_ins      <= NOP_INSTR;
      r_npc      <= '0;
      r_vld      <= 1'b0;
      r_hold_vld <= 1'b0;
      r_tcnt     <= '0;
      if (w_bad) begin
        r_state <= ERR;
        r_err   <= 1'b1;
      end else begin
        r_state <= FETCH;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          r_state <= FETCH;
          r_tcnt  <= '0;
        end
        FETCH: begin
          if (w_ack) begin
            r_pc   <= w_npc;
            r_tcnt <= '0;
            if (stall) begin
              r_hold_ins <= imem_rdata;
              r_hold_npc <= w_npc;
              r_hold_vld <= 1'b1;
              r_state    <= HOLD;
            end else begin
              r_ins <= imem_rdata;
              r_npc <= w_npc;
              r_vld <= 1'b1;
            end
          end else begin
            if (!stall) begin
              r_ins <= NOP_INSTR;
              r_vld <= 1'b0;
            end
            if (w_tmo) begin
              r_state <= ERR;
              r_err   <= 1'b1;
              r_tcnt  <= '0;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end
        HOLD: begin
          r_tcnt <= '0;
          if (!stall) begin
            r_ins      <= r_hold_ins;
            r_npc      <= r_hold_npc;
            r_vld      <= r_hold_vld;
            r_hold_vld <= 1'b0;
            r_state    <= FETCH;
          end
        end
        default: begin
          r_state <= ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl with a latency-programmable memory model.
// Accepted acks push expected IF/ID entries; fresh valid IF/ID loads pop them.
module tb_if_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clock;
  logic        reset;
  logic        exMemPc;
  logic [31:0] exMemIn;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] ifIdInstruction;
  logic [31:0] ifIdIn;
  logic        if_valid;
  logic        fetch_err;
  logic        misalign;

  int n_chk;
  int n_fail;
  int lat;
  int mcnt;
  logic [31:0] exp_pc;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] npc;
  } ent_t;

  ent_t q[$];

  if_fetch_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clock(clock),
    .reset(reset),
    .exMemPc(exMemPc),
    .exMemIn(exMemIn),
    .stall(stall),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .pc(pc),
    .ifIdInstruction(ifIdInstruction),
    .ifIdIn(ifIdIn),
    .if_valid(if_valid),
    .fetch_err(fetch_err),
    .misalign(misalign)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  assign imem_ack   = imem_req && (mcnt >= lat);
  assign imem_rdata = imem_addr ^ KEY;

  always @(posedge clock or posedge reset) begin
    if (reset) mcnt <= 0;
    else if (!imem_req || imem_ack || exMemPc) mcnt <= 0;
    else mcnt <= mcnt + 1;
  end

  always @(posedge clock) begin
    logic s;
    ent_t e;
    s = stall;
    if (!reset && imem_req && imem_ack && !exMemPc)
      q.push_back({imem_rdata, imem_addr + 32'd4});
    #1;
    if (!reset && !s && if_valid) begin
      chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_ins", ifIdInstruction, e.ins);
        chk("sb_npc", ifIdIn, e.npc);
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_ins"}, ifIdInstruction, NOP);
    chk({tag, "_npc"}, ifIdIn, 32'h0);
    chk({tag, "_vld"}, 32'(if_valid), 32'd0);
    chk({tag, "_err"}, 32'(fetch_err), 32'd0);
    chk({tag, "_mis"}, 32'(misalign), 32'd0);
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    reset   = 1'b1;
    stall   = 1'b0;
    exMemPc = 1'b0;
    exMemIn = '0;
    lat     = 0;
    exp_pc  = '0;
    repeat (2) @(negedge clock);
    chk_reset("rst");
    reset = 1'b0;

    // zero-wait streaming
    @(negedge clock);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    @(negedge clock);
    chk("zw_npc4", ifIdIn, 32'h4);
    chk("zw_ins0", ifIdInstruction, KEY);
    chk("zw_vld4", 32'(if_valid), 32'd1);
    @(negedge clock);
    chk("zw_npc8", ifIdIn, 32'h8);
    chk("zw_vld8", 32'(if_valid), 32'd1);
    @(negedge clock);
    chk("zw_npc12", ifIdIn, 32'hC);
    chk("zw_vld12", 32'(if_valid), 32'd1);

    // 3-cycle latency at 0x10
    @(negedge clock);
    lat = 2;
    chk("lat_req1", 32'(imem_req), 32'd1);
    chk("lat_addr1", imem_addr, 32'h10);
    @(negedge clock);
    chk("lat_addr2", imem_addr, 32'h10);
    chk("lat_bub1", 32'(if_valid), 32'd0);
    chk("lat_nop1", ifIdInstruction, NOP);
    @(negedge clock);
    chk("lat_req3", 32'(imem_req), 32'd1);
    chk("lat_addr3", imem_addr, 32'h10);
    chk("lat_bub2", 32'(if_valid), 32'd0);
    @(negedge clock);
    chk("lat_npc", ifIdIn, 32'h14);
    chk("lat_vld", 32'(if_valid), 32'd1);
    lat = 0;

    // stall at ack for pc 0x20
    for (int i = 0; i < 16 && pc != 32'h20; i++) @(negedge clock);
    chk("hold_pc", pc, 32'h20);
    chk("hold_pre", ifIdIn, 32'h20);
    stall = 1'b1;
    #1;
    chk("hold_ack", 32'(imem_ack), 32'd1);
    @(negedge clock);
    chk("hold_req1", 32'(imem_req), 32'd0);
    chk("hold_npc1", ifIdIn, 32'h20);
    chk("hold_ins1", ifIdInstruction, 32'h1C ^ KEY);
    @(negedge clock);
    chk("hold_req2", 32'(imem_req), 32'd0);
    chk("hold_npc2", ifIdIn, 32'h20);
    stall = 1'b0;
    @(negedge clock);
    chk("rel_npc", ifIdIn, 32'h24);
    chk("rel_vld", 32'(if_valid), 32'd1);
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, 32'h24);

    // redirect + ack + stall in the same cycle
    stall   = 1'b1;
    exMemPc = 1'b1;
    exMemIn = 32'h100;
    #1;
    chk("rd_ack", 32'(imem_ack), 32'd1);
    @(negedge clock);
    exMemPc = 1'b0;
    stall   = 1'b0;
    chk("rd_vld", 32'(if_valid), 32'd0);
    chk("rd_ins", ifIdInstruction, NOP);
    chk("rd_npc", ifIdIn, 32'h0);
    chk("rd_addr", imem_addr, 32'h100);
    @(negedge clock);
    chk("rd_next", ifIdIn, 32'h104);

    // redirect to a misaligned target
    exMemPc = 1'b1;
    exMemIn = 32'h102;
    @(negedge clock);
    exMemPc = 1'b0;
`ifdef IF_MISALIGN_EN
    chk("mis_flag", 32'(misalign), 32'd1);
    chk("mis_err", 32'(fetch_err), 32'd1);
    chk("mis_req", 32'(imem_req), 32'd0);
    chk("mis_pc", pc, 32'h102);
    lat   = 1000;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    exp_pc = 32'h0;
`else
    chk("al_addr", imem_addr, 32'h100);
    chk("al_req", 32'(imem_req), 32'd1);
    chk("al_mis", 32'(misalign), 32'd0);
    lat    = 1000;
    exp_pc = 32'h100;
`endif

    // timeout after 4 FETCH cycles without ack
    chk("to_err0", 32'(fetch_err), 32'd0);
    repeat (3) begin
      @(negedge clock);
      chk("to_err_lo", 32'(fetch_err), 32'd0);
      chk("to_req_hi", 32'(imem_req), 32'd1);
    end
    @(negedge clock);
    chk("to_err1", 32'(fetch_err), 32'd1);
    chk("to_req0", 32'(imem_req), 32'd0);
    chk("to_vld", 32'(if_valid), 32'd0);

    exMemPc = 1'b1;
    exMemIn = 32'h200;
    @(negedge clock);
    exMemPc = 1'b0;
    @(negedge clock);
    chk("err_req", 32'(imem_req), 32'd0);
    chk("err_pc", pc, exp_pc);
    chk("err_sticky", 32'(fetch_err), 32'd1);

    // asynchronous reset out of ERR
    reset = 1'b1;
    #1;
    chk_reset("rst2");
    @(negedge clock);
    chk("sb_drain", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Fetch-stage sequencer for the IF stage of the RISC-V pipeline. It owns the program counter, issues requests to a variable-latency instruction memory with a req/ack handshake, and loads the IF/ID pipeline register. It applies EX/MEM branch redirects, ID hazard stalls and flush bubbles, and flags memory timeouts.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NOP_INSTR`, 32'h0000_0013, bubble word (addi x0,x0,0) written to IF/ID on flush or empty fetch
- `MEM_TIMEOUT`, 15, cycles in FETCH without ack before error; 0 disables the timeout
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `exMemPc`  in  1  redirect (branch/jump taken) from EX/MEM
- `exMemIn`  in  32  redirect target
- `stall`  in  1  hazard stall from ID; IF/ID must hold
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address; equals `pc` while `imem_req`=1
- `imem_ack`  in  1  data valid on `imem_rdata`; sampled only while `imem_req`=1; may arrive in the same cycle as the request
- `imem_rdata`  in  32  instruction word
- `pc`  out  32  current fetch PC
- `ifIdInstruction`  out  32  IF/ID instruction field
- `ifIdIn`  out  32  IF/ID next-PC field (fetch address + 4)
- `if_valid`  out  1  IF/ID holds a real instruction (0 = bubble)
- `fetch_err`  out  1  sticky error; fetch halted
- `misalign`  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- FSM states: IDLE, FETCH, HOLD, ERR.
- Reset state: IDLE.
- Reset values: `pc`=RESET_PC, `imem_req`=0, `ifIdInstruction`=NOP_INSTR, `ifIdIn`=0, `if_valid`=0, `fetch_err`=0, `misalign`=0, hold buffer cleared, timeout counter 0.
- IDLE:
  - `imem_req`=0.
  - Moves to FETCH unconditionally on the next edge.
- FETCH:
  - `imem_req`=1, `imem_addr`=`pc`.
  - On ack: `pc` <= `pc`+4 (32-bit wrap at 32'hFFFF_FFFC -> 0).
  - Ack with `stall`=0: IF/ID <= {`imem_rdata`, `pc`+4, valid=1}; remain in FETCH.
  - Ack with `stall`=1: word and `pc`+4 go into the hold buffer; IF/ID unchanged; go to HOLD.
  - No ack with `stall`=0: IF/ID <= {NOP_INSTR, `ifIdIn` unchanged, valid=0}.
  - No ack with `stall`=1: IF/ID holds.
- HOLD:
  - `imem_req`=0.
  - When `stall`=0: IF/ID <= hold buffer with valid=1; go to FETCH.
- ERR:
  - `imem_req`=0.
  - IF/ID <= NOP with valid=0.
  - `exMemPc` is ignored.
  - Left only by `reset`.
- Redirect (`exMemPc`=1 in IDLE, FETCH or HOLD) has the highest priority:
  - `pc` <= `exMemIn`.
  - Any same-cycle ack is discarded.
  - Hold buffer is invalidated.
  - IF/ID <= {NOP_INSTR, 0, valid=0}, regardless of `stall`.
  - Next state is FETCH.
  - An unacked outstanding request is withdrawn; the memory must tolerate `imem_req` dropping or changing address before ack.
- Timeout:
  - The counter increments each FETCH cycle without ack.
  - It clears on ack, on redirect and on leaving FETCH.
  - When the counter reaches MEM_TIMEOUT (and MEM_TIMEOUT != 0): go to ERR and set `fetch_err`=1.
  - Counter width is $clog2(MEM_TIMEOUT+1).

## Timing
- All outputs except `imem_req`/`imem_addr` are registered; `imem_req`/`imem_addr` decode from state and `pc`.
- First request goes out in the cycle after reset release, after one IDLE cycle.
- Latency: ack in cycle N -> IF/ID valid from edge N+1.
- Zero-wait memory (ack in the same cycle as req) sustains 1 instruction/cycle.
- Stall: IF/ID contents are bit-stable while `stall`=1, except on redirect.
- At most one fetched word is buffered, so no request is issued in HOLD.
- Simultaneous ack + redirect + stall: redirect wins, the word is dropped and NOP is loaded.
- `reset` mid-fetch: outputs go to reset values immediately (asynchronous); any in-flight ack is ignored.

## Configuration
- `IF_MISALIGN_EN`:
  - Defined: a redirect target with `exMemIn[1:0]` != 0 sends the FSM to ERR, sets `misalign`=1 (sticky) and `fetch_err`=1, and flushes IF/ID to NOP. `pc` takes the faulting target for debug.
  - Undefined: `exMemIn[1:0]` is forced to 2'b00 on redirect, and `misalign` is tied to 0.

## Test plan
- Reset release, zero-wait memory returning `addr`^32'hA5A5_0000:
  - First request at `imem_addr`=0.
  - Consecutive IF/ID entries show `ifIdIn`=4, 8, 12, with `if_valid`=1 each cycle.
- 3-cycle ack latency:
  - `imem_req` and `imem_addr`=0x10 stay stable for 3 cycles.
  - IF/ID shows two bubbles (valid=0), then the word, with `ifIdIn`=0x14.
- `stall`=1 at the moment of ack at `pc`=0x20:
  - State goes to HOLD, `imem_req`=0, IF/ID unchanged.
  - `stall` dropped 2 cycles later: IF/ID loads the word with `ifIdIn`=0x24.
  - The next request goes to 0x24.
- `exMemPc`=1 with `exMemIn`=0x100 in the same cycle as an ack and `stall`=1:
  - IF/ID = NOP, valid=0.
  - Next request goes to 0x100.
  - The acked word never appears in IF/ID.
- MEM_TIMEOUT=4 and the memory never acks:
  - `fetch_err` rises after 4 FETCH cycles.
  - `imem_req`=0 thereafter, and a later `exMemPc` is ignored.
  - Asserting `reset` clears all outputs to their reset values.
- With `IF_MISALIGN_EN`, redirect to 0x102: `misalign`=1, `fetch_err`=1, state ERR.
- Without `IF_MISALIGN_EN`, redirect to 0x102: the next request goes to 0x100.
